ysyx_23060025_isram_rsp: RTL and testbench

AXI4-Lite read-only responder (slave) serving instruction fetches from the IFU read initiator.
- Accepts one read address on the AR channel and waits a programmable number of cycles.
- Returns one 32-bit word on the R channel with an OKAY/SLVERR/DECERR response.
- Backed by an internal word array, which the testbench or boot logic preloads through a simple backdoor write port.
- Sits between the IFU and the memory model in simulation tops; one outstanding transaction only.

---
 rtl/ysyx_23060025_isram_rsp_pkg.sv | 22 ++
 rtl/ysyx_23060025_isram_rsp_lfsr4.sv | 27 ++
 rtl/ysyx_23060025_isram_rsp.sv | 197 +++++++++++++++++++
 tb/tb_ysyx_23060025_isram_rsp.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060025_isram_rsp_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060025_isram_rsp_pkg
// Shared definitions for the instruction SRAM AXI4-Lite read responder.
//   - AXI read response codes
//   - responder FSM state encoding
//   - reset seed of the optional random-delay LFSR (RAND_DELAY_EN builds)
// ----------------------------------------------------------------------------
package ysyx_23060025_isram_rsp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ISRAM_IDLE = 2'b00,
        ISRAM_WAIT = 2'b01,
        ISRAM_RESP = 2'b10
    } isram_state_e;

    localparam logic [3:0] LFSR_SEED = 4'b0001;

endpackage

// File: rtl/ysyx_23060025_isram_rsp_lfsr4.sv
// ----------------------------------------------------------------------------
// ysyx_23060025_lfsr4
// 4-bit Fibonacci LFSR, polynomial x^4 + x^3 + 1, advancing every cycle.
// A non-zero seed walks all 15 non-zero states, so the value is never 0.
// Ports:
//   clock  in   clock
//   reset  in   synchronous, active-high; loads seed
//   seed   in   [3:0] value loaded on reset (must be non-zero)
//   value  out  [3:0] current LFSR state
// ----------------------------------------------------------------------------
module ysyx_23060025_lfsr4 (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] seed,
    output logic [3:0] value
);

    always_ff @(posedge clock) begin
        if (reset) begin
            value <= seed;
        end else begin
            // Taps at bits 3 and 2 realise x^4 + x^3 + 1 for a left shift.
            value <= {value[2:0], value[3] ^ value[2]};
        end
    end

endmodule

// File: rtl/ysyx_23060025_isram_rsp.sv
// ----------------------------------------------------------------------------
// ysyx_23060025_isram_rsp
// AXI4-Lite read-only responder serving IFU instruction fetches from an
// internal word array. One outstanding read; the array is preloaded through a
// backdoor write port.
//
// Timing: rvalid rises LATENCY+1 cycles after the AR handshake edge. The FSM
// enters RESP after LATENCY edges and the response (data + code) is captured
// on the following edge, so a backdoor load landing on or before the edge that
// enters RESP is seen, and anything later leaves the held beat untouched.
//
// Optional feature (macro RAND_DELAY_EN): the wait count is loaded from a
// 4-bit LFSR (1..15) instead of LATENCY, giving delays of 2..16 cycles.
//
// Ports:
//   clock    in   clock
//   reset    in   synchronous, active-high
//   araddr   in   [ADDR_WIDTH-1:0] read address
//   arvalid  in   read address valid
//   arready  out  responder accepts an address (registered, high in IDLE)
//   rdata    out  [DATA_WIDTH-1:0] read data (0 on error responses)
//   rresp    out  [1:0] 00 OKAY, 10 SLVERR (misaligned), 11 DECERR (range)
//   rvalid   out  read data valid
//   rready   in   initiator accepts the read data
//   ld_en    in   backdoor write strobe
//   ld_addr  in   [ADDR_WIDTH-1:0] backdoor absolute byte address
//   ld_data  in   [DATA_WIDTH-1:0] backdoor write data
// ----------------------------------------------------------------------------
module ysyx_23060025_isram_rsp
    import ysyx_23060025_isram_rsp_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    LATENCY    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data
);

    localparam int IDX_WIDTH = $clog2(DEPTH);
    // One extra bit so the byte span of the array never wraps.
    localparam logic [ADDR_WIDTH:0] SPAN_BYTES = (ADDR_WIDTH + 1)'(4 * DEPTH);

    isram_state_e          state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [3:0]            load_cnt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Address decode: offsets are taken modulo 2^ADDR_WIDTH, and the range
    // check uses the full offset so aliases above the array are rejected.
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] ar_off, ld_off;
    logic                  ar_in_range, ld_in_range;
    logic [IDX_WIDTH-1:0]  ar_idx, ld_idx;

    assign ar_off      = addr_q - BASE_ADDR;
    assign ar_in_range = {1'b0, ar_off} < SPAN_BYTES;
    assign ar_idx      = ar_off[IDX_WIDTH+1:2];

    assign ld_off      = ld_addr - BASE_ADDR;
    assign ld_in_range = {1'b0, ld_off} < SPAN_BYTES;
    assign ld_idx      = ld_off[IDX_WIDTH+1:2];

    // ------------------------------------------------------------------
    // Wait-count source
    // ------------------------------------------------------------------
`ifdef RAND_DELAY_EN
    logic [3:0] lfsr_value;

    ysyx_23060025_lfsr4 u_lfsr (
        .clock (clock),
        .reset (reset),
        .seed  (LFSR_SEED),
        .value (lfsr_value)
    );

    assign load_cnt = lfsr_value;
`else
    assign load_cnt = 4'(LATENCY);
`endif

    // ------------------------------------------------------------------
    // Backing array
    // ------------------------------------------------------------------
    // NOTE: the array has no reset branch; clearing it would turn the RAM into
    // thousands of resettable flops, and the contents are preloaded anyway.
    always_ff @(posedge clock) begin
        if (ld_en && ld_in_range) begin
            mem[ld_idx] <= ld_data;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        unique case (state_q)
            ISRAM_IDLE: begin
                if (arvalid && arready_q) begin
                    addr_d  = araddr;
                    cnt_d   = load_cnt;
                    state_d = (load_cnt == 4'd0) ? ISRAM_RESP : ISRAM_WAIT;
                end
            end
            ISRAM_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ISRAM_RESP;
                end
            end
            ISRAM_RESP: begin
                if (rvalid_q && rready) begin
                    state_d = ISRAM_IDLE;
                end
            end
            default: state_d = ISRAM_IDLE;
        endcase
    end

    // Response for the latched address, evaluated against current contents.
    always_comb begin
        rresp_d = RESP_OKAY;
        rdata_d = '0;
        if (!ar_in_range) begin
            rresp_d = RESP_DECERR;
        end else if (addr_q[1:0] != 2'b00) begin
            rresp_d = RESP_SLVERR;
        end else begin
            rdata_d = mem[ar_idx];
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ISRAM_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            arready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            // Registered so it rises on the same edge the R beat completes.
            arready_q <= (state_d == ISRAM_IDLE);
        end
    end

    // The beat is captured on the first RESP edge and held until accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (state_q == ISRAM_RESP && !rvalid_q) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end else if (rvalid_q && rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_ysyx_23060025_isram_rsp.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060025_isram_rsp
// Two responders share clock, reset and the backdoor port: u_lat2 (LATENCY=2)
// and u_lat0 (LATENCY=0). Expected responses come from a word-array model and
// plain address arithmetic; expected delays from LATENCY or, with
// RAND_DELAY_EN, from the listed LFSR sequence indexed by cycles since reset.
// ----------------------------------------------------------------------------
module tb_ysyx_23060025_isram_rsp;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          LAT_A = 2;
    localparam int          LAT_B = 0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [1:0]       arvalid_v, rready_v, arready_w, rvalid_w;
    logic [1:0][31:0] araddr_v, rdata_w;
    logic [1:0][1:0]  rresp_w;
    logic             ld_en;
    logic [31:0]      ld_addr, ld_data;

    ysyx_23060025_isram_rsp #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH),
        .BASE_ADDR(BASE), .LATENCY(LAT_A)
    ) u_lat2 (
        .clock(clock), .reset(reset),
        .araddr(araddr_v[0]), .arvalid(arvalid_v[0]), .arready(arready_w[0]),
        .rdata(rdata_w[0]), .rresp(rresp_w[0]), .rvalid(rvalid_w[0]), .rready(rready_v[0]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    ysyx_23060025_isram_rsp #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH),
        .BASE_ADDR(BASE), .LATENCY(LAT_B)
    ) u_lat0 (
        .clock(clock), .reset(reset),
        .araddr(araddr_v[1]), .arvalid(arvalid_v[1]), .arready(arready_w[1]),
        .rdata(rdata_w[1]), .rresp(rresp_w[1]), .rvalid(rvalid_w[1]), .rready(rready_v[1]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_mem [DEPTH];

`ifdef RAND_DELAY_EN
    int unsigned cyc_since_reset = 0;
    int          lfsr_seq [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
    always @(posedge clock) begin
        if (reset) cyc_since_reset <= 0;
        else       cyc_since_reset <= cyc_since_reset + 1;
    end
`endif

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  resp;
        logic [31:0] data;
        int          hold;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit in_array(input logic [31:0] a);
        longint unsigned la = {32'd0, a};
        longint unsigned lo = {32'd0, BASE};
        return (la >= lo) && (la < lo + 4 * DEPTH);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
        if (in_array(a)) model_mem[(a - BASE) / 4] = d;
    endfunction

    function automatic void ref_rsp(input logic [31:0] a, output logic [1:0] r, output logic [31:0] d);
        if (!in_array(a)) begin
            r = 2'b11; d = 32'd0;
        end else if (a % 4 != 0) begin
            r = 2'b10; d = 32'd0;
        end else begin
            r = 2'b00; d = model_mem[(a - BASE) / 4];
        end
    endfunction

    // Cycles from the AR handshake edge to the edge that raises rvalid.
    function automatic int exp_delay(input int d);
`ifdef RAND_DELAY_EN
        return lfsr_seq[cyc_since_reset % 15] + 1;
`else
        return (d == 0 ? LAT_A : LAT_B) + 1;
`endif
    endfunction

    task automatic ld_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        model_write(a, d);
        @(negedge clock);
        ld_en = 1'b0;
    endtask

    // One complete read on responder d. ld_mode 1 loads ld_val into the target
    // word on the handshake edge; ld_mode 2 loads it while the beat is held
    // (hold >= 2) and the held beat must not change.
    task automatic do_read(input int d, input logic [31:0] a, input int hold,
                           input int ld_mode, input logic [31:0] ld_val,
                           input logic [1:0] exp_resp, input logic [31:0] exp_data,
                           input string tag);
        int n;
        int dly;
        int exp_d;
        logic [1:0]  r0;
        logic [31:0] d0;
        @(negedge clock);
        araddr_v[d] = a; arvalid_v[d] = 1'b1;
        n = 0;
        while (!arready_w[d] && n < 64) begin
            @(negedge clock);
            n++;
        end
        check({tag, " arready"}, 32'(arready_w[d]), 32'd1);
        if (!arready_w[d]) begin
            arvalid_v[d] = 1'b0;
            return;
        end
        exp_d = exp_delay(d);
        if (ld_mode == 1) begin
            ld_en = 1'b1; ld_addr = a; ld_data = ld_val;
            model_write(a, ld_val);
        end
        @(posedge clock);
        @(negedge clock);
        arvalid_v[d] = 1'b0;
        ld_en = 1'b0;
        check({tag, " arready_drop"}, 32'(arready_w[d]), 32'd0);
        dly = 0;
        while (!rvalid_w[d] && dly < 40) begin
            @(posedge clock);
            dly++;
            @(negedge clock);
        end
        check({tag, " delay"}, 32'(dly), 32'(exp_d));
`ifdef RAND_DELAY_EN
        check({tag, " delay_range"}, 32'(dly >= 2 && dly <= 16), 32'd1);
`endif
        check({tag, " rresp"}, 32'(rresp_w[d]), 32'(exp_resp));
        check({tag, " rdata"}, rdata_w[d], exp_data);
        r0 = rresp_w[d];
        d0 = rdata_w[d];
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check({tag, " hold_rvalid"}, 32'(rvalid_w[d]), 32'd1);
            check({tag, " hold_rdata"}, rdata_w[d], d0);
            check({tag, " hold_rresp"}, 32'(rresp_w[d]), 32'(r0));
            check({tag, " hold_arready"}, 32'(arready_w[d]), 32'd0);
            if (ld_mode == 2 && i == 0) begin
                ld_en = 1'b1; ld_addr = a; ld_data = ld_val;
                model_write(a, ld_val);
            end else begin
                ld_en = 1'b0;
            end
        end
        ld_en = 1'b0;
        rready_v[d] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rready_v[d] = 1'b0;
        check({tag, " rvalid_drop"}, 32'(rvalid_w[d]), 32'd0);
        check({tag, " arready_back"}, 32'(arready_w[d]), 32'd1);
    endtask

    initial begin
        logic [1:0]  er;
        logic [31:0] ed;
        logic [31:0] a;
        int          n;
        int          seen;
        int          d;

        vecs[0] = '{32'h8000_0000, 2'b00, 32'h0000_0413, 5};
        vecs[1] = '{32'h7FFF_FFFC, 2'b11, 32'h0000_0000, 0};
        vecs[2] = '{32'h8000_1000, 2'b11, 32'h0000_0000, 1};
        vecs[3] = '{32'h8000_0002, 2'b10, 32'h0000_0000, 0};
        vecs[4] = '{32'h8000_0FFC, 2'b00, 32'hDEAD_BEEF, 0};
        vecs[5] = '{32'h8000_0FFF, 2'b10, 32'h0000_0000, 0};
        vecs[6] = '{32'h0000_0000, 2'b11, 32'h0000_0000, 0};
        vecs[7] = '{32'hFFFF_FFFC, 2'b11, 32'h0000_0000, 0};
        vecs[8] = '{32'h0000_0FFC, 2'b11, 32'h0000_0000, 2};

        arvalid_v = '0; rready_v = '0; araddr_v = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        // Reset state
        repeat (3) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            check("reset arready", 32'(arready_w[i]), 32'd0);
            check("reset rvalid", 32'(rvalid_w[i]), 32'd0);
            check("reset rdata", rdata_w[i], 32'd0);
            check("reset rresp", 32'(rresp_w[i]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clock);
        check("post_reset arready lat2", 32'(arready_w[0]), 32'd1);
        check("post_reset arready lat0", 32'(arready_w[1]), 32'd1);

        // Preload both arrays
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            ld_en = 1'b1;
            ld_addr = BASE + 32'(4 * i);
            ld_data = (i == 0) ? 32'h0000_0413 : (i == DEPTH - 1) ? 32'hDEAD_BEEF : $urandom;
            model_write(ld_addr, ld_data);
        end
        @(negedge clock);
        ld_en = 1'b0;

        // Table-driven vectors on the LATENCY=2 responder
        foreach (vecs[i]) begin
            do_read(0, vecs[i].addr, vecs[i].hold, 0, 32'd0, vecs[i].resp, vecs[i].data,
                    $sformatf("vec%0d", i));
        end

        // LATENCY=0 back-to-back reads
        ref_rsp(32'h8000_0000, er, ed);
        do_read(1, 32'h8000_0000, 0, 0, 32'd0, er, ed, "b2b first");
        ref_rsp(32'h8000_0004, er, ed);
        do_read(1, 32'h8000_0004, 0, 0, 32'd0, er, ed, "b2b second");

        // Load landing on the edge that enters RESP is visible
        do_read(1, 32'h8000_0014, 0, 1, 32'hCAFE_0014, 2'b00, 32'hCAFE_0014, "early_ld");

        // Load while the beat is held leaves it unchanged, next read sees it
        ref_rsp(32'h8000_001C, er, ed);
        do_read(0, 32'h8000_001C, 3, 2, 32'h5A5A_001C, er, ed, "late_ld");
        do_read(0, 32'h8000_001C, 0, 0, 32'd0, 2'b00, 32'h5A5A_001C, "late_ld reread");

        // Out-of-range loads are dropped and must not alias into the array
        ld_word(32'h8000_1000, 32'h1234_5678);
        ld_word(32'h7FFF_FFFC, 32'h8765_4321);
        do_read(0, 32'h8000_0000, 0, 0, 32'd0, 2'b00, 32'h0000_0413, "oor_ld word0");
        do_read(1, 32'h8000_0FFC, 0, 0, 32'd0, 2'b00, 32'hDEAD_BEEF, "oor_ld last");

        // Reset one cycle after the AR handshake aborts the read
        @(negedge clock);
        araddr_v[0] = 32'h8000_0010; arvalid_v[0] = 1'b1;
        n = 0;
        while (!arready_w[0] && n < 64) begin
            @(negedge clock);
            n++;
        end
        check("rst_mid arready", 32'(arready_w[0]), 32'd1);
        @(posedge clock);
        @(negedge clock);
        arvalid_v[0] = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid arready in reset", 32'(arready_w[0]), 32'd0);
        check("rst_mid rvalid in reset", 32'(rvalid_w[0]), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("rst_mid arready after", 32'(arready_w[0]), 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rvalid_w[0]) seen++;
            @(negedge clock);
        end
        check("rst_mid no rvalid", 32'(seen), 32'd0);
        ref_rsp(32'h8000_0010, er, ed);
        do_read(0, 32'h8000_0010, 0, 0, 32'd0, er, ed, "rst_mid fresh");

        // Randomized reads against the model
        for (int i = 0; i < 60; i++) begin
            n = $urandom_range(0, 9);
            if (n < 6)      a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (n < 8) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            else            a = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                ld_word(BASE + 32'(4 * $urandom_range(0, DEPTH - 1)), $urandom);
            end
            d = $urandom_range(0, 1);
            ref_rsp(a, er, ed);
            do_read(d, a, $urandom_range(0, 3), 0, 32'd0, er, ed, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
